// File: rtl/cipher_nibble_rx.sv
// rtl/cipher_nibble_rx.sv - serial ciphertext nibble receiver with XOR decrypt and plaintext FIFO
// Optional macro PARITY_CHK_EN adds an even-parity bit after d3 and the par_err check.
module cipher_nibble_rx #(
    parameter int BAUD_DIV = 16,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxd,
    input  logic [3:0]       key,
    input  logic             rd_en,
    output logic [3:0]       rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             frame_err,
    output logic             par_err,
    output logic             ovf
);

    localparam int TMR_W = $clog2(BAUD_DIV);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [TMR_W-1:0] HALF_M1 = TMR_W'(BAUD_DIV / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_M1 = TMR_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state, state_nxt;

    logic             rx_s1, rx_s2, rx_prev;
    logic             fall;
    logic [TMR_W-1:0] tmr;
    logic             half_hit, full_hit;
    logic [1:0]       bit_cnt;
    logic [3:0]       shift_reg;
    logic             par_mis;

    logic             stop_smp, push, ferr_c, perr_c;
    logic             wr_ok, do_pop;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [3:0]       mem [DEPTH];

    // rxd is asynchronous; rx_prev gives the falling-edge detector its history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign fall     = rx_prev & ~rx_s2;
    assign half_hit = (tmr == HALF_M1);
    assign full_hit = (tmr == FULL_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (fall) state_nxt = S_START;
            S_START:  if (half_hit) state_nxt = rx_s2 ? S_IDLE : S_DATA;
            S_DATA: begin
                if (full_hit && bit_cnt == 2'd3) begin
`ifdef PARITY_CHK_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
            S_PARITY: if (full_hit) state_nxt = S_STOP;
            S_STOP:   if (full_hit) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        stop_smp = (state == S_STOP) && full_hit;
        push     = stop_smp && rx_s2 && !par_mis;
        ferr_c   = stop_smp && !rx_s2;
        perr_c   = stop_smp && rx_s2 && par_mis;
    end

    assign busy = (state != S_IDLE);

    // Timer sits at 0 in IDLE so START always begins counting from 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr       <= '0;
            bit_cnt   <= 2'd0;
            shift_reg <= 4'h0;
        end else begin
            if (state == S_IDLE || (state == S_START && half_hit) || full_hit)
                tmr <= '0;
            else
                tmr <= tmr + TMR_W'(1);

            if (state == S_IDLE) begin
                bit_cnt <= 2'd0;
            end else if (state == S_DATA && full_hit) begin
                shift_reg <= {rx_s2, shift_reg[3:1]};
                bit_cnt   <= bit_cnt + 2'd1;
            end
        end
    end

`ifdef PARITY_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par_mis <= 1'b0;
        else if (state == S_IDLE)
            par_mis <= 1'b0;
        else if (state == S_PARITY && full_hit)
            par_mis <= (^shift_reg) ^ rx_s2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_err <= 1'b0;
        else     par_err <= perr_c;
    end
`else
    assign par_mis = 1'b0;
    assign par_err = 1'b0;
`endif

    // When full, a same-cycle read frees the head slot, which becomes the new tail
    assign wr_ok  = push && (!full || rd_en);
    assign do_pop = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= shift_reg ^ key;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (wr_ok)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_ok, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            frame_err <= ferr_c;
            ovf       <= push && full && !rd_en;
        end
    end

    assign empty    = (count == '0);
    assign full     = (count == CNT_MAX);
    assign rd_valid = !empty;
    assign rd_data  = empty ? 4'h0 : mem[rd_ptr];

endmodule
